// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg_if : upstream/downstream valid-ready bus of one stage |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32
);
   logic              in_valid_in;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_data_in;
   logic              out_valid_o;
   logic              out_ready_in;
   logic [DATA_W-1:0] out_data_o;

   // master drives beats in and backpressure out; slave is the stage itself
   modport master (
      output in_valid_in, in_data_in, out_ready_in,
      input  in_ready_o, out_valid_o, out_data_o
   );
   modport slave (
      input  in_valid_in, in_data_in, out_ready_in,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready stage register with skid entry, flush   |
// | and saturating stall counter.                Revision: 1.0           |
// +----------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 16,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  wire logic             clk_in,
   input  wire logic             rst_in,
   input  wire logic             flush_in,
   pipe_stage_reg_if.slave       bus,
   output logic [1:0]            occupancy_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);
   localparam logic [1:0]       c_st_empty = 2'd0;
   localparam logic [1:0]       c_st_full  = 2'd1;
   localparam logic [1:0]       c_st_skid  = 2'd2;
   localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [DATA_W-1:0] r_main_q;
   logic [DATA_W-1:0] r_skid_q;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_main_v;
   logic              w_skid_v;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_send;

   assign w_accept = bus.in_valid_in & w_in_ready;
   assign w_send   = w_main_v & bus.out_ready_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= c_st_empty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush_in) begin
         w_state_nxt = c_st_empty;
      end else begin
         case (r_state)
            c_st_empty: if (w_accept) w_state_nxt = c_st_full;
            c_st_full: begin
               if (w_accept && !w_send)      w_state_nxt = c_st_skid;
               else if (!w_accept && w_send) w_state_nxt = c_st_empty;
            end
            c_st_skid:  if (w_send) w_state_nxt = c_st_full;
            default:    w_state_nxt = c_st_empty;
         endcase
      end
   end

   // ready depends only on the state register, so it never combinationally follows out_ready_in
   always_comb begin
      w_main_v   = 1'b0;
      w_skid_v   = 1'b0;
      w_in_ready = 1'b1;
      case (r_state)
         c_st_full: w_main_v = 1'b1;
         c_st_skid: begin
            w_main_v   = 1'b1;
            w_skid_v   = 1'b1;
            w_in_ready = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_main_q <= '0;
         r_skid_q <= '0;
      end else if (flush_in) begin
         if (CLEAR_ON_FLUSH) begin
            r_main_q <= '0;
            r_skid_q <= '0;
         end
      end else begin
         case (r_state)
            c_st_empty: if (w_accept) r_main_q <= bus.in_data_in;
            c_st_full: begin
               if (w_accept && w_send) r_main_q <= bus.in_data_in;
               else if (w_accept)      r_skid_q <= bus.in_data_in;
            end
            c_st_skid:  if (w_send) r_main_q <= r_skid_q;
            default: ;
         endcase
      end
   end

   // flush does not clear the counter; a stalled flush cycle still counts
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_stall_cnt <= '0;
      end else if (w_main_v && !bus.out_ready_in && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.in_ready_o  = w_in_ready;
   assign bus.out_valid_o = w_main_v;
   assign bus.out_data_o  = r_main_q;
   assign occupancy_o     = {1'b0, w_main_v} + {1'b0, w_skid_v};
   assign stall_cnt_o     = r_stall_cnt;
endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register; the generalised successor to the fixed decode-to-execute register.
- Carries an opaque packed payload of DATA_W bits, such as the decode bundle (rd addr, rs1/rs2, pc+4, imm, ALU opcode, load size, wb sel, rf_wr_en), from an upstream stage to a downstream stage.
- Adds valid/ready flow control, a one-entry skid buffer so in_ready_o is fully registered, pipeline flush, and a saturating stall counter.
- Sits between any two datapath stages (IF/ID, ID/EX, EX/MEM) with one instance per boundary.

Parameters:
- DATA_W, 32, payload width in bits; legal range 1..512.
- CNT_W, 16, stall counter width; legal range 1..32.
- CLEAR_ON_FLUSH, 1, when 1 a flush zeroes both payload registers; when 0 a flush only clears the valid bits.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous reset, active-high.
- flush_in  input  1  discard all held entries and any beat accepted in the same cycle.
- in_valid_in  input  1  upstream beat valid.
- in_ready_o  output  1  stage can accept a beat; registered.
- in_data_in  input  DATA_W  upstream payload.
- out_valid_o  output  1  output beat valid; registered.
- out_ready_in  input  1  downstream accepts the beat.
- out_data_o  output  DATA_W  output payload; registered, equal to the main register.
- occupancy_o  output  2  entries held: 0, 1 or 2.
- stall_cnt_o  output  CNT_W  count of cycles in which out_valid_o=1 and out_ready_in=0.

Behaviour:
- Interface (already decided): one clock, clk_in; reset rst_in is synchronous and active-high.
- Storage is a main register (main_q, main_v) and a skid register (skid_q, skid_v).
- Port mapping:
  - out_valid_o = main_v; out_data_o = main_q.
  - in_ready_o = !skid_v.
  - occupancy_o = main_v + skid_v.
- Transfer definitions: accept = in_valid_in & in_ready_o; send = out_valid_o & out_ready_in.
- States and transitions, evaluated each rising edge:
  - EMPTY (0 entries):
    - accept -> FULL, main_q <= in_data_in.
  - FULL (main valid, skid empty):
    - accept & send -> FULL, main_q <= in_data_in.
    - send only -> EMPTY.
    - accept & !out_ready_in -> SKID, skid_q <= in_data_in.
    - neither -> FULL, main_q held.
  - SKID (both valid; in_ready_o=0):
    - send -> FULL, main_q <= skid_q, skid_v <= 0.
    - otherwise hold.
- Latency: a beat accepted at edge N is visible on out_data_o after edge N; minimum latency is 1 cycle. Throughput is one beat per cycle while out_ready_in=1.
- Ordering is strictly FIFO. No beat is duplicated or lost unless a flush discards it.
- Upstream may present in_valid_in while in_ready_o=0; nothing is captured and the upstream holds its data.
- Reset (rst_in=1 at an edge), highest priority:
  - main_v, skid_v, main_q, skid_q <= 0, so out_valid_o=0, out_data_o=0, occupancy_o=0 and in_ready_o=1 after the edge.
  - stall_cnt_o <= 0.
- Flush (flush_in=1, rst_in=0), second priority:
  - main_v, skid_v <= 0; the next state is EMPTY.
  - A beat with in_valid_in=1 in the same cycle is dropped, not captured.
  - A send in the same cycle still counts as delivered downstream; the downstream owns that beat.
  - With CLEAR_ON_FLUSH=1, main_q and skid_q <= 0. With CLEAR_ON_FLUSH=0, the payload registers keep stale values.
  - stall_cnt_o is not cleared by flush.
- Stall counter: +1 on every edge where out_valid_o=1 and out_ready_in=0 and rst_in=0. It saturates at 2^CNT_W-1 and does not wrap. It counts during a flush cycle if the condition holds.
- Payload is opaque; no bit of it is interpreted or modified.

Test Plan:
- Reset with DATA_W=32: hold rst_in=1 for 2 cycles with in_valid_in=1 and in_data_in=0xDEADBEEF -> out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1, stall_cnt_o=0.
- Streaming: out_ready_in=1; drive beats 0x11, 0x22, 0x33 on consecutive cycles -> out_data_o shows 0x11, 0x22, 0x33 one cycle later each; occupancy_o=1 throughout; in_ready_o stays 1.
- Backpressure and skid:
  - Drive 0xA1 then 0xA2 while out_ready_in=0 -> occupancy_o=2, in_ready_o=0, out_data_o=0xA1.
  - Offer 0xA3 for 3 cycles -> not captured.
  - Raise out_ready_in -> outputs 0xA1, 0xA2, 0xA3 in order; stall_cnt_o=4.
- Flush in SKID with a simultaneous in_valid_in (0xB3) -> next cycle occupancy_o=0, out_valid_o=0, out_data_o=0 (CLEAR_ON_FLUSH=1); 0xB3 never appears at the output.
- CLEAR_ON_FLUSH=0: flush while holding 0xC5 -> out_valid_o=0, out_data_o remains 0xC5.
- Saturation with CNT_W=3: hold out_valid_o=1 and out_ready_in=0 for 10 cycles -> stall_cnt_o=7 and stays 7; a subsequent flush leaves 7; rst_in returns it to 0.
